// File: rtl/clock_cal_supervisor.sv
// Calibration supervisor for the CLOCK block: sequences reset/wait attempts,
// steps the init trim code on error or timeout, and relocks after lock loss.
module clock_cal_supervisor #(
    parameter int unsigned RESET_CYCLES = 100,
    parameter int unsigned TIMEOUT      = 65535,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned INIT_STEP    = 64
) (
    input  logic        ref_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_target,
    input  logic [15:0] req_ref,
    input  logic [8:0]  req_init,
    output logic        clk_resetn,
    output logic [15:0] clk_counter,
    output logic [15:0] clk_ref_counter,
    output logic [8:0]  clk_init,
    input  logic [2:0]  clk_status,
    output logic        locked,
    output logic        failed,
    output logic [1:0]  retries
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT,
        S_LOCKED,
        S_FAIL
    } state_t;

    localparam logic [31:0] HOLD_LAST   = RESET_CYCLES;
    localparam logic [31:0] TIMER_LAST  = TIMEOUT - 1;
    localparam logic [1:0]  RETRY_LIMIT = MAX_RETRY[1:0];
    localparam logic [8:0]  TRIM_STEP   = INIT_STEP[8:0];

    state_t      state;
    logic [31:0] hold_cnt;
    logic [31:0] timer;
    logic        handshake;
    logic        attempt_bad;
    logic        unused_status;

    // Bit 0 of the CLOCK status carries nothing this stage acts on.
    assign unused_status = clk_status[0];

    assign req_ready = (state == S_IDLE) || (state == S_LOCKED) || (state == S_FAIL);
    assign handshake = req_valid && req_ready;

    // An attempt ends badly on error, or on timeout when no lock arrived in the final cycle.
    assign attempt_bad = clk_status[2] || (!clk_status[1] && (timer == TIMER_LAST));

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values; async reset clears everything without a clock.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            hold_cnt        <= '0;
            timer           <= '0;
            clk_resetn      <= 1'b0;
            clk_counter     <= '0;
            clk_ref_counter <= '0;
            clk_init        <= '0;
            locked          <= 1'b0;
            failed          <= 1'b0;
            retries         <= '0;
        end else if (handshake) begin
            clk_counter     <= req_target;
            clk_ref_counter <= req_ref;
            clk_init        <= req_init;
            retries         <= '0;
            locked          <= 1'b0;
            failed          <= 1'b0;
            hold_cnt        <= '0;
            clk_resetn      <= 1'b0;
            state           <= S_HOLD;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        clk_resetn <= 1'b1;
                        timer      <= '0;
                        state      <= S_WAIT;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (attempt_bad) begin
                        clk_resetn <= 1'b0;
                        if (retries < RETRY_LIMIT) begin
                            retries  <= retries + 2'd1;
                            clk_init <= clk_init + TRIM_STEP;
                            hold_cnt <= '0;
                            state    <= S_HOLD;
                        end else begin
                            failed <= 1'b1;
                            state  <= S_FAIL;
                        end
                    end else if (clk_status[1]) begin
                        locked <= 1'b1;
                        state  <= S_LOCKED;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_LOCKED: begin
                    // Lock loss: relock with the trim code that last worked.
                    if (!clk_status[1] || clk_status[2]) begin
                        locked     <= 1'b0;
                        retries    <= '0;
                        hold_cnt   <= '0;
                        clk_resetn <= 1'b0;
                        state      <= S_HOLD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_cal_supervisor.sv
// Directed bench for clock_cal_supervisor: expected snapshots are queued as
// stimulus is applied and popped/compared after the clock edge that produces them.
module tb_clock_cal_supervisor;

    localparam int RC   = 4;
    localparam int TO   = 50;
    localparam int MR   = 2;
    localparam int STEP = 64;

    logic        ref_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_target = '0;
    logic [15:0] req_ref    = '0;
    logic [8:0]  req_init   = '0;
    logic        clk_resetn;
    logic [15:0] clk_counter;
    logic [15:0] clk_ref_counter;
    logic [8:0]  clk_init;
    logic [2:0]  clk_status = '0;
    logic        locked;
    logic        failed;
    logic [1:0]  retries;

    clock_cal_supervisor #(
        .RESET_CYCLES(RC),
        .TIMEOUT     (TO),
        .MAX_RETRY   (MR),
        .INIT_STEP   (STEP)
    ) dut (
        .ref_clk        (ref_clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_target     (req_target),
        .req_ref        (req_ref),
        .req_init       (req_init),
        .clk_resetn     (clk_resetn),
        .clk_counter    (clk_counter),
        .clk_ref_counter(clk_ref_counter),
        .clk_init       (clk_init),
        .clk_status     (clk_status),
        .locked         (locked),
        .failed         (failed),
        .retries        (retries)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct {
        string       tag;
        logic        resetn;
        logic [15:0] cnt;
        logic [15:0] refc;
        logic [8:0]  init;
        logic        locked;
        logic        failed;
        logic [1:0]  retries;
        logic        ready;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] m_cnt  = '0;
    logic [15:0] m_ref  = '0;
    logic [8:0]  m_init = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic resetn, input logic lk,
                                input logic fl, input logic [1:0] rt, input logic rdy);
        exp_t e;
        e.tag     = tag;
        e.resetn  = resetn;
        e.cnt     = m_cnt;
        e.refc    = m_ref;
        e.init    = m_init;
        e.locked  = lk;
        e.failed  = fl;
        e.retries = rt;
        e.ready   = rdy;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty observed=0 entries expected=1");
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".resetn"},  32'(clk_resetn),      32'(e.resetn));
        check({e.tag, ".counter"}, 32'(clk_counter),     32'(e.cnt));
        check({e.tag, ".ref"},     32'(clk_ref_counter), 32'(e.refc));
        check({e.tag, ".init"},    32'(clk_init),        32'(e.init));
        check({e.tag, ".locked"},  32'(locked),          32'(e.locked));
        check({e.tag, ".failed"},  32'(failed),          32'(e.failed));
        check({e.tag, ".retries"}, 32'(retries),         32'(e.retries));
        check({e.tag, ".ready"},   32'(req_ready),       32'(e.ready));
    endtask

    task automatic step();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic edge_check(input string tag, input logic resetn, input logic lk,
                              input logic fl, input logic [1:0] rt, input logic rdy);
        expect_state(tag, resetn, lk, fl, rt, rdy);
        step();
        compare();
    endtask

    task automatic handshake(input logic [15:0] t, input logic [15:0] r, input logic [8:0] i);
        req_target = t;
        req_ref    = r;
        req_init   = i;
        req_valid  = 1'b1;
        m_cnt      = t;
        m_ref      = r;
        m_init     = i;
        edge_check("handshake", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        req_valid  = 1'b0;
    endtask

    // Edges 1..RC after the attempt start keep CLOCK in reset; edge RC+1 releases it.
    task automatic run_hold(input logic [1:0] rt);
        repeat (RC - 1) step();
        edge_check("hold_last", 1'b0, 1'b0, 1'b0, rt, 1'b0);
        edge_check("wait_entry", 1'b1, 1'b0, 1'b0, rt, 1'b0);
    endtask

    // Runs a silent WAIT up to the last cycle before timeout.
    task automatic wait_to_last(input logic [1:0] rt);
        repeat (TO - 2) step();
        edge_check("wait_last", 1'b1, 1'b0, 1'b0, rt, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, observed with no clock edge yet.
        #2;
        expect_state("reset_vals", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        compare();
        #1 reset = 1'b0;
        edge_check("idle", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        // 1. Clean lock.
        handshake(16'd6000, 16'd10, 9'd20);
        run_hold(2'd0);
        repeat (5) step();
        edge_check("pre_lock", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        clk_status = 3'b010;
        edge_check("lock", 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);

        // 2. Error in attempts 1 and 2, lock in attempt 3.
        clk_status = 3'b000;
        handshake(16'd6000, 16'd10, 9'd20);
        run_hold(2'd0);
        repeat (3) step();
        clk_status = 3'b100;
        m_init = 9'd84;
        edge_check("err1", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        clk_status = 3'b000;
        run_hold(2'd1);
        repeat (2) step();
        clk_status = 3'b100;
        m_init = 9'd148;
        edge_check("err2", 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        clk_status = 3'b000;
        run_hold(2'd2);
        clk_status = 3'b010;
        edge_check("lock3", 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);

        // 3. Three timeouts, then FAIL.
        clk_status = 3'b000;
        handshake(16'd6000, 16'd10, 9'd20);
        run_hold(2'd0);
        wait_to_last(2'd0);
        m_init = 9'd84;
        edge_check("timeout1", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        run_hold(2'd1);
        wait_to_last(2'd1);
        m_init = 9'd148;
        edge_check("timeout2", 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        run_hold(2'd2);
        wait_to_last(2'd2);
        edge_check("fail", 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
        edge_check("fail_stays", 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);

        // 4. Init wrap and error-over-lock priority.
        handshake(16'd6000, 16'd10, 9'd500);
        run_hold(2'd0);
        clk_status = 3'b110;
        m_init = 9'(((500 + STEP) % 512));
        edge_check("err_wins_wrap", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        clk_status = 3'b000;

        // 5. Lock, lose lock, relock, then restart while locked.
        run_hold(2'd1);
        clk_status = 3'b010;
        edge_check("lock_a", 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
        clk_status = 3'b000;
        edge_check("lock_loss", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        run_hold(2'd0);
        clk_status = 3'b010;
        edge_check("relock", 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        clk_status = 3'b000;
        handshake(16'd1234, 16'd77, 9'd300);

        // 6. Async reset mid-WAIT, between edges.
        run_hold(2'd0);
        step();
        step();
        #3 reset = 1'b1;
        #1;
        m_cnt  = '0;
        m_ref  = '0;
        m_init = '0;
        expect_state("async_reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        compare();
        #2 reset = 1'b0;
        edge_check("post_reset_idle", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        edge_check("idle_stays", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
